// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage rv32i core: stall/flush steering, E-stage forwarding
// selects and a data-memory wait watchdog. Optional perf counters: HAZ_PERF_CNT_EN.

module hazard_fwd_sel (
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       regwrite_m_i,
    input  logic       regwrite_w_i,
    output logic [1:0] sel_o
);
    // M is the younger producer, so it beats W.
    always_comb begin
        sel_o = 2'b00;
        if (regwrite_m_i && rd_m_i != 5'd0 && rd_m_i == rs_i)
            sel_o = 2'b10;
        else if (regwrite_w_i && rd_w_i != 5'd0 && rd_w_i == rs_i)
            sel_o = 2'b01;
    end
endmodule

module hazard_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs1_d,
    input  logic [4:0]        rs2_d,
    input  logic [4:0]        rs1_e,
    input  logic [4:0]        rs2_e,
    input  logic [4:0]        rd_e,
    input  logic [4:0]        rd_m,
    input  logic [4:0]        rd_w,
    input  logic [1:0]        ResultSrc_e,
    input  logic              RegWrite_m,
    input  logic              RegWrite_w,
    input  logic              PCSrc_e,
    input  logic              mem_req_m,
    input  logic              mem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic [1:0]        ForwardA_e,
    output logic [1:0]        ForwardB_e,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] perf_lu_cnt,
    output logic [PERF_W-1:0] perf_fl_cnt,
    output logic [PERF_W-1:0] perf_mw_cnt
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam int NOPS = 2;

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        state_q;
    logic [CW-1:0] wait_cnt_q;
    logic          mem_timeout_q;
    logic          lu, mw;

    logic [NOPS-1:0][4:0] rs_e;
    logic [NOPS-1:0][1:0] fwd;

    assign rs_e = {rs2_e, rs1_e};

    for (genvar g = 0; g < NOPS; g++) begin : g_fwd
        hazard_fwd_sel u_fwd (
            .rs_i         (rs_e[g]),
            .rd_m_i       (rd_m),
            .rd_w_i       (rd_w),
            .regwrite_m_i (RegWrite_m),
            .regwrite_w_i (RegWrite_w),
            .sel_o        (fwd[g])
        );
    end

    assign ForwardA_e = fwd[0];
    assign ForwardB_e = fwd[1];

    assign lu = (ResultSrc_e == 2'b01) && (rd_e != 5'd0) && (rd_e == rs1_d || rd_e == rs2_d);
    assign mw = mem_req_m && !mem_ready;

    // A memory wait freezes every stage up to M; a bubble enters W. Gated by reset so
    // the controls drop asynchronously with rst_n.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst_n) begin
            if (mw) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = lu;
                stall_d = lu;
                flush_d = PCSrc_e;
                flush_e = lu | PCSrc_e;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mw) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= CW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt_q == CW'(MEM_TIMEOUT))
                        mem_timeout_q <= 1'b1;
                    if (mw) begin
                        if (wait_cnt_q != '1)
                            wait_cnt_q <= wait_cnt_q + CW'(1);
                    end else begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] lu_cnt_q, fl_cnt_q, mw_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
            mw_cnt_q <= '0;
        end else begin
            if (lu && !mw && lu_cnt_q != '1)      lu_cnt_q <= lu_cnt_q + PERF_W'(1);
            if (PCSrc_e && !mw && fl_cnt_q != '1) fl_cnt_q <= fl_cnt_q + PERF_W'(1);
            if (mw && mw_cnt_q != '1)             mw_cnt_q <= mw_cnt_q + PERF_W'(1);
        end
    end

    assign perf_lu_cnt = lu_cnt_q;
    assign perf_fl_cnt = fl_cnt_q;
    assign perf_mw_cnt = mw_cnt_q;
`else
    assign perf_lu_cnt = '0;
    assign perf_fl_cnt = '0;
    assign perf_mw_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios then random traffic, all
// compared against a behavioural model built from the hazard rules.

module tb_hazard_unit;
    localparam int MT = 4;
    localparam int PW = 32;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] ResultSrc_e;
    logic RegWrite_m, RegWrite_w, PCSrc_e, mem_req_m, mem_ready;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
    logic [1:0] ForwardA_e, ForwardB_e;
    logic [PW-1:0] perf_lu_cnt, perf_fl_cnt, perf_mw_cnt;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(MT), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .ResultSrc_e(ResultSrc_e), .RegWrite_m(RegWrite_m), .RegWrite_w(RegWrite_w),
        .PCSrc_e(PCSrc_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .ForwardA_e(ForwardA_e), .ForwardB_e(ForwardB_e), .mem_timeout(mem_timeout),
        .perf_lu_cnt(perf_lu_cnt), .perf_fl_cnt(perf_fl_cnt), .perf_mw_cnt(perf_mw_cnt)
    );

    int ncmp = 0;
    int nerr = 0;

    // Reference state: length of the current run of wait cycles, sticky flag, event tallies.
    int streak = 0;
    logic exp_to = 1'b0;
    int n_lu = 0, n_fl = 0, n_mw = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (RegWrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (RegWrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        ResultSrc_e = 0; RegWrite_m = 0; RegWrite_w = 0; PCSrc_e = 0;
        mem_req_m = 0; mem_ready = 1;
    endtask

    task automatic model_reset();
        streak = 0; exp_to = 1'b0; n_lu = 0; n_fl = 0; n_mw = 0;
    endtask

    task automatic check_regs();
        check("mem_timeout", 32'(mem_timeout), 32'(exp_to));
        check("perf_lu", perf_lu_cnt, PERF ? n_lu : 0);
        check("perf_fl", perf_fl_cnt, PERF ? n_fl : 0);
        check("perf_mw", perf_mw_cnt, PERF ? n_mw : 0);
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic cycle();
        logic lu, mw;
        #1;
        lu = (ResultSrc_e == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        mw = mem_req_m && !mem_ready;
        check("stall_f", 32'(stall_f), 32'(mw || lu));
        check("stall_d", 32'(stall_d), 32'(mw || lu));
        check("stall_e", 32'(stall_e), 32'(mw));
        check("stall_m", 32'(stall_m), 32'(mw));
        check("flush_w", 32'(flush_w), 32'(mw));
        check("flush_d", 32'(flush_d), 32'(!mw && PCSrc_e));
        check("flush_e", 32'(flush_e), 32'(!mw && (lu || PCSrc_e)));
        check("ForwardA", 32'(ForwardA_e), 32'(fwd_ref(rs1_e)));
        check("ForwardB", 32'(ForwardB_e), 32'(fwd_ref(rs2_e)));
        @(posedge clk);
        if (streak == MT) exp_to = 1'b1;
        streak = mw ? streak + 1 : 0;
        if (lu && !mw) n_lu++;
        if (PCSrc_e && !mw) n_fl++;
        if (mw) n_mw++;
        #1;
        check_regs();
        @(negedge clk);
    endtask

    initial begin
        idle();
        #2;
        check("rst_stall_f", 32'(stall_f), 0);
        check("rst_flush_w", 32'(flush_w), 0);
        check_regs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Load-use then forward from M.
        idle(); rd_e = 5; ResultSrc_e = 2'b01; rs1_d = 5;
        #1 check("lu_flush_d", 32'(flush_d), 0);
        cycle();
        idle(); rd_m = 5; RegWrite_m = 1; rs1_e = 5;
        #1 check("fwdA_m", 32'(ForwardA_e), 32'(2'b10));
        cycle();

        // M beats W, W alone, x0 never forwards.
        idle(); rd_m = 3; rd_w = 3; RegWrite_m = 1; RegWrite_w = 1; rs2_e = 3;
        cycle();
        RegWrite_m = 0;
        #1 check("fwdB_w", 32'(ForwardB_e), 32'(2'b01));
        cycle();
        rd_m = 0; rd_w = 0; RegWrite_m = 1; rs2_e = 0;
        cycle();

        // Load-use coincident with a taken branch.
        idle(); rd_e = 7; ResultSrc_e = 2'b01; rs2_d = 7; PCSrc_e = 1;
        #1 check("lu_br_stall_d", 32'(stall_d), 1);
        cycle();

        // Three wait cycles with a branch held in E.
        idle(); PCSrc_e = 1; mem_req_m = 1; mem_ready = 0;
        repeat (3) cycle();
        mem_ready = 1;
        #1 check("wait_rel_flush_d", 32'(flush_d), 1);
        cycle();

        // Watchdog: long wait, flag stays after release, cleared by async reset.
        idle(); mem_req_m = 1; mem_ready = 0;
        repeat (7) cycle();
        check("to_set", 32'(mem_timeout), 1);
        mem_ready = 1;
        repeat (2) cycle();
        mem_ready = 0;
        cycle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_stall_m", 32'(stall_m), 0);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Perf scenario: 2 load-use, 1 flush, 3 waits.
        idle(); rd_e = 9; ResultSrc_e = 2'b01; rs1_d = 9;
        repeat (2) cycle();
        idle(); PCSrc_e = 1;
        cycle();
        idle(); mem_req_m = 1; mem_ready = 0;
        repeat (3) cycle();
        idle();
        cycle();
        check("perf_lu_2", perf_lu_cnt, PERF ? 2 : 0);
        check("perf_fl_1", perf_fl_cnt, PERF ? 1 : 0);
        check("perf_mw_3", perf_mw_cnt, PERF ? 3 : 0);

        // Random traffic over a small register range to provoke hits.
        for (int i = 0; i < 400; i++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            ResultSrc_e = 2'($urandom_range(0, 3));
            RegWrite_m = 1'($urandom); RegWrite_w = 1'($urandom);
            PCSrc_e = ($urandom_range(0, 3) == 0);
            mem_req_m = 1'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0) ? (i < 200) : 1'b0;
            if (i == 250) begin
                rst_n = 1'b0;
                model_reset();
                #1 check_regs();
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
